// File: rtl/pcs_lane_channel_emulator.sv
// Multi-lane PCS channel impairment model: per-lane block skew, lane
// permutation with fan-out, and periodic deterministic bit-error injection.
// All impairments are applied in one registered stage (1-cycle latency).
module pcs_lane_channel_emulator #(
  parameter int NB_DATA        = 66,
  parameter int N_LANES        = 20,
  parameter int MAX_SKEW       = 16,
  parameter int NB_SKEW        = $clog2(MAX_SKEW+1),
  parameter int NB_LANE_ID     = $clog2(N_LANES),
  parameter int NB_ERR_PERIOD  = 32,
  parameter int NB_ERR_COUNTER = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_valid,
  input  logic [N_LANES*NB_DATA-1:0]    i_data,
  input  logic [N_LANES*NB_SKEW-1:0]    i_rf_skew,
  input  logic [N_LANES*NB_LANE_ID-1:0] i_rf_lane_perm,
  input  logic [NB_ERR_PERIOD-1:0]      i_rf_err_period,
  input  logic [N_LANES-1:0]            i_rf_err_lane_mask,
  input  logic [NB_DATA-1:0]            i_rf_err_bit_mask,
  output logic                          o_valid,
  output logic [N_LANES*NB_DATA-1:0]    o_data,
  output logic [NB_ERR_COUNTER-1:0]     o_err_count
);

  // One slot more than the maximum skew so the oldest needed block is never
  // overwritten by the block being written in the same cycle.
  localparam int DEPTH  = MAX_SKEW + 1;
  localparam int NB_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N_LANES-1:0][NB_DATA-1:0]    din;
  logic [N_LANES-1:0][NB_SKEW-1:0]    skew;
  logic [N_LANES-1:0][NB_LANE_ID-1:0] perm;
  logic [N_LANES-1:0][NB_DATA-1:0]    dly;
  logic [N_LANES-1:0][NB_DATA-1:0]    imp;

  logic [NB_DATA-1:0]       mem [N_LANES][DEPTH];
  logic [NB_PTR-1:0]        wp;
  logic [NB_ERR_PERIOD-1:0] ec;
  logic                     inject;
  int                       s_eff;
  int                       rd;

  assign din  = i_data;
  assign skew = i_rf_skew;
  assign perm = i_rf_lane_perm;

  // Delay lookup per input lane, then permutation and error XOR per output lane.
  always_comb begin
    s_eff  = 0;
    rd     = 0;
    dly    = '0;
    imp    = '0;
    inject = i_enable && i_valid && (i_rf_err_period != '0) &&
             (ec == i_rf_err_period - 1'b1);
    for (int l = 0; l < N_LANES; l++) begin
      s_eff = int'(skew[l]);
      if (s_eff > MAX_SKEW) s_eff = MAX_SKEW;
      // Modulo DEPTH subtraction; DEPTH need not be a power of two.
      rd = int'(wp) - s_eff;
      if (rd < 0) rd = rd + DEPTH;
      dly[l] = (s_eff == 0) ? din[l] : mem[l][NB_PTR'(rd)];
    end
    for (int k = 0; k < N_LANES; k++) begin
      // Out-of-range selectors produce an idle (all-zero) lane.
      if (int'(perm[k]) < N_LANES) imp[k] = dly[perm[k]];
      if (inject && i_rf_err_lane_mask[k]) imp[k] = imp[k] ^ i_rf_err_bit_mask;
    end
  end

  // Skew buffers advance only on valid blocks while enabled.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int l = 0; l < N_LANES; l++)
        for (int d = 0; d < DEPTH; d++)
          mem[l][d] <= '0;
    end else if (i_enable && i_valid) begin
      for (int l = 0; l < N_LANES; l++)
        mem[l][wp] <= din[l];
    end
  end

  // Output register, write pointer, error period counter and event counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_err_count <= '0;
      wp          <= '0;
      ec          <= '0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_data <= i_enable ? imp : i_data;
      if (i_enable && i_valid)
        wp <= (wp == NB_PTR'(DEPTH-1)) ? '0 : wp + 1'b1;
      if (i_enable) begin
        if (i_rf_err_period == '0) ec <= '0;
        else if (i_valid)          ec <= inject ? '0 : ec + 1'b1;
      end
      if (inject && (o_err_count != '1)) o_err_count <= o_err_count + 1'b1;
    end
  end

endmodule
